// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the program counter, registers the fetched word
// into the fetch/decode pipeline register, and handles stall and redirect.
module fetch_unit #(
  parameter int                     PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] ProgCounter,
  input  logic [31:0]         InstrIn,
  input  logic                Stall,
  input  logic                Jump,
  input  logic [PC_WIDTH-1:0] JumpTarget,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget,
  output logic [31:0]         InstrOut,
  output logic [PC_WIDTH-1:0] PCOut,
  output logic [PC_WIDTH-1:0] PCPlus4,
  output logic                InstrValid,
  output logic                FetchFault
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc_out;
  logic                r_valid;
  logic                r_fault;

  logic                w_redirect;
  logic [PC_WIDTH-1:0] w_target;
  logic                w_misaligned;

  // Jump outranks a simultaneous taken branch; only the chosen target is checked.
  assign w_redirect   = Jump | BranchTaken;
  assign w_target     = Jump ? JumpTarget : BranchTarget;
  assign w_misaligned = |w_target[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else if (w_redirect) begin
      // Redirect wins over stall; the word at the old PC is wrong-path and dropped.
      r_pc     <= {w_target[PC_WIDTH-1:2], 2'b00};
      r_instr  <= '0;
      r_pc_out <= r_pc;
      r_valid  <= 1'b0;
      if (w_misaligned) begin
        r_fault <= 1'b1;
      end
    end else if (!Stall) begin
      r_pc     <= r_pc + PC_STEP;
      r_instr  <= InstrIn;
      r_pc_out <= r_pc;
      r_valid  <= 1'b1;
    end
  end

  assign ProgCounter = r_pc;
  assign InstrOut    = r_instr;
  assign PCOut       = r_pc_out;
  assign PCPlus4     = r_pc_out + PC_STEP;
  assign InstrValid  = r_valid;
  assign FetchFault  = r_fault;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that owns the program counter and drives the 10-bit byte address into the instruction memory, whose 32-bit read is combinational. It registers the returned word into a fetch/decode pipeline register with a valid bit. The pipeline register feeds decode. The block handles sequential fetch, stall hold, and jump/branch redirects; a redirect squashes the wrong-path instruction.

Parameters:
PC_WIDTH, 10, byte-address width of the program counter (matches the 1024-entry instruction memory address input).
RESET_PC, 0, byte address loaded into ProgCounter on reset; must be a multiple of 4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
ProgCounter  output  PC_WIDTH  current fetch byte address, to the instruction memory.
InstrIn  input  32  instruction word returned combinationally by the instruction memory for ProgCounter.
Stall  input  1  hold request from decode/hazard logic.
Jump  input  1  unconditional redirect request.
JumpTarget  input  PC_WIDTH  byte address for Jump.
BranchTaken  input  1  resolved taken-branch redirect request.
BranchTarget  input  PC_WIDTH  byte address for a taken branch.
InstrOut  output  32  registered instruction to decode.
PCOut  output  PC_WIDTH  address InstrOut was fetched from.
PCPlus4  output  PC_WIDTH  PCOut + 4, mod 2^PC_WIDTH; combinational from PCOut; used for link.
InstrValid  output  1  InstrOut holds a real instruction; when 0, decode treats InstrOut as a NOP.
FetchFault  output  1  sticky flag: a misaligned redirect target was seen.

Behaviour:
- Reset values (reset high at a clock edge):
  - ProgCounter = RESET_PC.
  - InstrOut = 0, PCOut = 0, InstrValid = 0, FetchFault = 0.
  - Reset overrides every other input.
- Per-cycle priority, evaluated at each edge: reset > Jump > BranchTaken > Stall > sequential.
- Sequential (no Jump, no BranchTaken, Stall = 0):
  - ProgCounter <= ProgCounter + 4.
  - InstrOut <= InstrIn, PCOut <= ProgCounter, InstrValid <= 1.
- Stall (Stall = 1, no redirect):
  - ProgCounter, InstrOut, PCOut and InstrValid all hold.
  - InstrIn is ignored. Stall may persist for any number of cycles.
- Redirect (Jump = 1, or BranchTaken = 1):
  - ProgCounter <= {target[PC_WIDTH-1:2], 2'b00}.
  - InstrOut <= 0, InstrValid <= 0, PCOut <= ProgCounter. The word at the current ProgCounter is wrong-path and is dropped.
  - A redirect takes effect even if Stall = 1, so a redirect is never lost behind a stall.
  - If Jump and BranchTaken are both 1, JumpTarget wins.
- Latency:
  - The instruction at address A appears on InstrOut with InstrValid = 1 on the edge after ProgCounter = A, absent stall or redirect.
  - Redirect penalty: exactly one bubble (InstrValid = 0) cycle. The target instruction is valid one cycle after that.
- Alignment:
  - Only the chosen redirect target is checked. If its [1:0] != 0, FetchFault <= 1 and stays 1 until reset.
  - ProgCounter is still loaded with the target's bits [1:0] cleared.
  - The sequential path never produces misalignment.
- Wrap-around:
  - ProgCounter + 4 is modulo 2^PC_WIDTH; with default parameters, 1020 -> 0 with no flag.
  - PCPlus4 wraps identically.
- Reset asserted mid-stall or mid-redirect: the next state is the reset state; pending requests are discarded.
- First edge after reset deasserts: InstrOut captures the word at RESET_PC, InstrValid = 1, ProgCounter = RESET_PC + 4.
- Pure synchronous logic: no latches, no combinational path from the redirect/stall inputs to ProgCounter.

Test Plan:
- Reset then free run (memory word at address A = A, RESET_PC = 0) -> ProgCounter 0, 4, 8, 12. InstrOut 0x0, 0x4, 0x8 with InstrValid = 1 from the first post-reset edge; PCOut 0, 4, 8; PCPlus4 4, 8, 12.
- Stall held 3 cycles while ProgCounter = 16 -> ProgCounter stays 16; InstrOut/PCOut hold (InstrOut = 0xC, PCOut = 12) for 3 cycles. Fetch resumes: InstrOut = 0x10, PCOut = 16, then 0x14, PCOut = 20.
- BranchTaken = 1, BranchTarget = 100 while ProgCounter = 40 -> next cycle ProgCounter = 100, InstrValid = 0, InstrOut = 0. The cycle after: InstrOut = word at 100, PCOut = 100, InstrValid = 1.
- Jump = 1 (JumpTarget = 200) and BranchTaken = 1 (BranchTarget = 300) in the same cycle, with Stall = 1 -> ProgCounter = 200, one bubble, then word at 200 valid.
- Jump with JumpTarget = 0x0CA (misaligned) -> ProgCounter = 0x0C8, FetchFault = 1. FetchFault still 1 after 10 normal cycles; cleared only by reset.
- PC at 1020, no stall -> next ProgCounter = 0; PCPlus4 for PCOut = 1020 reads 0. Reset asserted the same cycle as Jump -> ProgCounter = RESET_PC, InstrValid = 0.
